mig_ui_responder: RTL and testbench
===================================

MIG_UI_RESPONDER -- requirements
Module: mig_ui_responder

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  DATA_W, 128, user data width.
  MEM_AW, 12, backing-store index width (4096 beats).
  CALIB_CYCLES, 200, cycles from reset release to calibration done.
  RD_LAT, 6, cycles from read-command acceptance to read data.
  STALL_EN, 0, 1 enables pseudo-random app_rdy stalls.
  LFSR_SEED, 16'hACE1, stall LFSR reset value.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  ui_clk, in, 1, sole clock.
  ui_clk_sync_rst, in, 1, synchronous active-high reset.
  init_calib_complete, out, 1, calibration done.
  app_addr, in, 28, column address; one beat = 8.
  app_cmd, in, 3, 0 = write, 1 = read.
  app_en, in, 1, command valid.
  app_rdy, out, 1, command accepted when high with app_en.
  app_wdf_data, in, DATA_W, write data.
  app_wdf_mask, in, DATA_W/8, byte mask; 1 = do not write.
  app_wdf_wren, in, 1, write data valid.
  app_wdf_end, in, 1, last beat of burst.
  app_wdf_rdy, out, 1, write data accepted when high with app_wdf_wren.
  app_rd_data, out, DATA_W, read data.
  app_rd_data_valid, out, 1, read data valid.
  app_rd_data_end, out, 1, equals app_rd_data_valid.
  proto_err, out, 1, sticky protocol-violation flag.
REQ-003 SHALL use one clock, ui_clk; reset ui_clk_sync_rst is synchronous and active-high.

Function
REQ-004 SHALL implement FSM CALIB -> READY. CALIB counts CALIB_CYCLES, then moves to READY. init_calib_complete SHALL be high only in READY and rises exactly CALIB_CYCLES cycles after reset deasserts.
REQ-005 app_rdy and app_wdf_rdy SHALL be registered, with no combinational path from any input.
REQ-006 app_rdy SHALL be high in READY unless a stall is active. A stall is active when STALL_EN=1 and the 16-bit Fibonacci LFSR (taps 16,14,13,11) has lfsr[2:0]==0. The LFSR advances every cycle.
REQ-007 Write data SHALL enter a 4-entry FIFO on app_wdf_wren && app_wdf_rdy. app_wdf_rdy is high in READY when the FIFO holds at most 2 entries.
REQ-008 A write command is accepted on app_en && app_rdy && app_cmd==0. It SHALL pop one FIFO entry, or take same-cycle bypass data when the FIFO is empty. It SHALL commit the unmasked bytes to mem[app_addr[MEM_AW+2:3]] on the same edge.
REQ-009 A write command accepted with no data available SHALL be dropped and SHALL set proto_err.
REQ-010 A read command is accepted on app_en && app_rdy && app_cmd==1. It SHALL produce exactly one app_rd_data_valid pulse exactly RD_LAT cycles later, in command order, with no back-pressure.
REQ-011 A read SHALL return the data of every write accepted in an earlier cycle.
REQ-012 Address bits above MEM_AW+2 SHALL be ignored, so addresses alias modulo 2^(MEM_AW+3). app_addr[2:0] nonzero SHALL set proto_err; the access still proceeds.
REQ-013 Any app_cmd other than 0 or 1 SHALL be accepted with no effect and SHALL set proto_err.
REQ-014 app_wdf_wren without app_wdf_end SHALL set proto_err; the data is still accepted.
REQ-015 app_rd_data SHALL hold its last value when app_rd_data_valid is low.

Reset
REQ-016 On reset, every output SHALL be 0: init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, app_rd_data, proto_err.
REQ-017 On reset, the FSM SHALL go to CALIB, counters clear, and the LFSR loads LFSR_SEED.
REQ-018 Reset mid-operation SHALL flush the write FIFO and all in-flight reads; no valid pulse appears after reset. Memory contents SHALL be retained.

Structure
REQ-019 Package mig_ui_pkg SHALL hold CMD_WRITE=3'd0, CMD_READ=3'd1, the FSM state encoding, and the LFSR taps.
REQ-020 The backing store SHALL be a single sub-module, mig_ui_ram: a simple-dual-port, byte-enable, synchronous-read RAM. The read pipeline pads to RD_LAT.

Verification
REQ-021 Calibration: release reset -> init_calib_complete rises at cycle 200; app_rdy and app_wdf_rdy are low before it.
REQ-022 Write/read: write 128'h0123..EF to addr 0x40 with mask 0, then read 0x40 -> valid pulses 6 cycles after acceptance with data 128'h0123..EF.
REQ-023 Mask: write all-ones to 0x80 with mask 16'h00FF over prior zeros, then read -> data 128'hFFFF..FF00..00 (bytes 15..8 = FF).
REQ-024 Back-to-back: 16 reads issued on consecutive cycles with STALL_EN=1 -> exactly 16 in-order valid pulses, each 6 cycles after its acceptance.
REQ-025 Errors: app_cmd=3 -> proto_err=1; write command with empty FIFO -> proto_err=1 and memory unchanged.
REQ-026 Reset: assert reset 2 cycles after a read is accepted -> no app_rd_data_valid; a later read returns the pre-reset memory data.

Source files
------------

// File: rtl/mig_ui_pkg.sv
// Shared command codes, FSM encoding and stall-LFSR definition for the MIG UI responder model.
// Pure definitions: no latency, no flow control.
package mig_ui_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;

  typedef enum logic {
    ST_CALIB = 1'b0,
    ST_READY = 1'b1
  } ui_state_e;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/mig_ui_ram.sv
// Simple-dual-port byte-enable RAM; write commits on the edge, read data registered one cycle later.
// No back-pressure: both ports accept an access every cycle; contents are never reset.
module mig_ui_ram #(
  parameter int DATA_W = 128,
  parameter int AW     = 12
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_dat,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_W-1:0]     rd_dat
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_dat[b*8 +: 8];
      end
    end
    if (rd_en) rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/mig_ui_responder.sv
// Behavioural MIG user-interface responder: calibration delay, 4-deep write-data FIFO, RAM store.
// Reads return RD_LAT cycles after acceptance; app_rdy/app_wdf_rdy are registered and may stall.
module mig_ui_responder
  import mig_ui_pkg::*;
#(
  parameter int          DATA_W       = 128,
  parameter int          MEM_AW       = 12,
  parameter int          CALIB_CYCLES = 200,
  parameter int          RD_LAT       = 6,
  parameter int          STALL_EN     = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  output logic                  init_calib_complete,
  input  logic [27:0]           app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_W-1:0]     app_wdf_data,
  input  logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_W-1:0]     app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  output logic                  proto_err
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (CALIB_CYCLES > 2) ? $clog2(CALIB_CYCLES) : 1;
  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_CYCLES - 1);

  ui_state_e           state_q, state_d;
  logic [CW-1:0]       calib_cnt_q, calib_cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic                app_rdy_q, app_rdy_d;
  logic                app_wdf_rdy_q, app_wdf_rdy_d;
  logic                proto_err_q, proto_err_d;

  logic [DATA_W-1:0]   fifo_dat_q [4];
  logic [DATA_W-1:0]   fifo_dat_d [4];
  logic [NB-1:0]       fifo_msk_q [4];
  logic [NB-1:0]       fifo_msk_d [4];
  logic [1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]          cnt_q, cnt_d;

  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [DATA_W-1:0]   stg_dat_q [1:RD_LAT-1];
  logic [DATA_W-1:0]   stg_dat_d [1:RD_LAT-1];

  logic                cmd_acc, wr_cmd, rd_cmd, bad_cmd;
  logic                wdf_acc, fifo_empty, wr_pop, wr_byp, wr_drop, push;
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_idx;
  logic [DATA_W-1:0]   mem_wdat, ram_rd_dat;
  logic [NB-1:0]       mem_be;
  logic                unused_addr_hi;

  // Upper address bits alias away by construction.
  assign unused_addr_hi = ^app_addr[27:MEM_AW+3];
  assign mem_idx        = app_addr[MEM_AW+2:3];

  always_comb begin
    state_d     = state_q;
    calib_cnt_d = calib_cnt_q;
    case (state_q)
      ST_CALIB: begin
        if (calib_cnt_q == CALIB_LAST) state_d = ST_READY;
        else                           calib_cnt_d = calib_cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_acc    = app_en && app_rdy_q && !ui_clk_sync_rst;
    wr_cmd     = cmd_acc && (app_cmd == CMD_WRITE);
    rd_cmd     = cmd_acc && (app_cmd == CMD_READ);
    bad_cmd    = cmd_acc && (app_cmd != CMD_WRITE) && (app_cmd != CMD_READ);
    wdf_acc    = app_wdf_wren && app_wdf_rdy_q && !ui_clk_sync_rst;
    fifo_empty = (cnt_q == 3'd0);
    wr_pop     = wr_cmd && !fifo_empty;
    // An empty FIFO lets same-cycle write data go straight to the RAM.
    wr_byp     = wr_cmd && fifo_empty && wdf_acc;
    wr_drop    = wr_cmd && fifo_empty && !wdf_acc;
    push       = wdf_acc && !wr_byp;
    mem_we     = wr_pop || wr_byp;
    mem_wdat   = wr_pop ? fifo_dat_q[rptr_q] : app_wdf_data;
    mem_be     = ~(wr_pop ? fifo_msk_q[rptr_q] : app_wdf_mask);
  end

  always_comb begin
    fifo_dat_d = fifo_dat_q;
    fifo_msk_d = fifo_msk_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      fifo_dat_d[wptr_q] = app_wdf_data;
      fifo_msk_d[wptr_q] = app_wdf_mask;
      wptr_d             = wptr_q + 2'd1;
    end
    if (wr_pop) rptr_d = rptr_q + 2'd1;
    case ({push, wr_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Ready flags are computed from next-cycle state so they stay pure flops.
  always_comb begin
    lfsr_d        = lfsr_step(lfsr_q);
    app_rdy_d     = (state_d == ST_READY) && !((STALL_EN != 0) && (lfsr_d[2:0] == 3'b000));
    app_wdf_rdy_d = (state_d == ST_READY) && (cnt_d <= 3'd2);
    proto_err_d   = proto_err_q || bad_cmd || wr_drop
                    || (cmd_acc && (app_addr[2:0] != 3'b000))
                    || (wdf_acc && !app_wdf_end);
  end

  always_comb begin
    vld_d     = {vld_q[RD_LAT-2:0], rd_cmd};
    stg_dat_d = stg_dat_q;
    if (vld_q[0]) stg_dat_d[1] = ram_rd_dat;
    for (int k = 2; k < RD_LAT; k++) begin
      if (vld_q[k-1]) stg_dat_d[k] = stg_dat_q[k-1];
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q       <= ST_CALIB;
      calib_cnt_q   <= '0;
      lfsr_q        <= LFSR_SEED;
      app_rdy_q     <= 1'b0;
      app_wdf_rdy_q <= 1'b0;
      proto_err_q   <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      vld_q         <= '0;
      for (int k = 1; k < RD_LAT; k++) stg_dat_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      calib_cnt_q   <= calib_cnt_d;
      lfsr_q        <= lfsr_d;
      app_rdy_q     <= app_rdy_d;
      app_wdf_rdy_q <= app_wdf_rdy_d;
      proto_err_q   <= proto_err_d;
      fifo_dat_q    <= fifo_dat_d;
      fifo_msk_q    <= fifo_msk_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      vld_q         <= vld_d;
      stg_dat_q     <= stg_dat_d;
    end
  end

  mig_ui_ram #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_ram (
    .clk     (ui_clk),
    .wr_en   (mem_we),
    .wr_addr (mem_idx),
    .wr_be   (mem_be),
    .wr_dat  (mem_wdat),
    .rd_en   (rd_cmd),
    .rd_addr (mem_idx),
    .rd_dat  (ram_rd_dat)
  );

  assign init_calib_complete = (state_q == ST_READY);
  assign app_rdy             = app_rdy_q;
  assign app_wdf_rdy         = app_wdf_rdy_q;
  assign app_rd_data         = stg_dat_q[RD_LAT-1];
  assign app_rd_data_valid   = vld_q[RD_LAT-1];
  assign app_rd_data_end     = vld_q[RD_LAT-1];
  assign proto_err           = proto_err_q;

endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed plus randomized checks of mig_ui_responder against a queue/array reference model.
module tb_mig_ui_responder;

  localparam int CALIB = 200;
  localparam int LAT   = 6;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, calib, en, rdy, wren, wend, wrdy, rvld, rend, perr;
  logic [27:0]  addr;
  logic [2:0]   cmd;
  logic [127:0] wdat, rdat;
  logic [15:0]  wmask;

  mig_ui_responder #(
    .DATA_W(128), .MEM_AW(12), .CALIB_CYCLES(CALIB), .RD_LAT(LAT),
    .STALL_EN(1), .LFSR_SEED(16'hACE1)
  ) dut (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(calib),
    .app_addr(addr), .app_cmd(cmd), .app_en(en), .app_rdy(rdy),
    .app_wdf_data(wdat), .app_wdf_mask(wmask), .app_wdf_wren(wren),
    .app_wdf_end(wend), .app_wdf_rdy(wrdy), .app_rd_data(rdat),
    .app_rd_data_valid(rvld), .app_rd_data_end(rend), .proto_err(perr)
  );

  typedef struct {int due; logic [127:0] dat;} rexp_t;

  int            ncmp = 0, nfail = 0, cyc = 0, since_rst = 0, nvld = 0, acc_cyc = 0;
  logic          chk_en = 1'b0, err_m = 1'b0;
  logic [15:0]   lfsr_m = 16'hACE1;
  logic [127:0]  last_dat = '0;
  logic [127:0]  mem_m [int];
  logic [127:0]  wq_dat [$];
  logic [15:0]   wq_msk [$];
  rexp_t         rq [$];
  rexp_t         mon_r;

  localparam logic [127:0] PAT  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] MPAT = {64'hFFFFFFFFFFFFFFFF, 64'h0};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      since_rst = 0;
      lfsr_m    = 16'hACE1;
      last_dat  = '0;
    end else begin
      since_rst++;
      lfsr_m = lfsr_adv(lfsr_m);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("calib_level", calib, since_rst >= CALIB);
      chk("app_rdy_level", rdy, (since_rst >= CALIB) && (lfsr_m[2:0] != 3'b000));
      if (since_rst < CALIB) chk("wdf_rdy_in_calib", wrdy, 1'b0);
      chk("rd_end", rend, rvld);
      if (rvld) begin
        nvld++;
        chk("rd_valid_expected", rvld, 1'(rq.size() != 0));
        if (rq.size() != 0) begin
          mon_r = rq.pop_front();
          chk("rd_latency", cyc, mon_r.due);
          chk("rd_data", rdat, mon_r.dat);
        end
        last_dat = rdat;
      end else begin
        chk("rd_hold", rdat, last_dat);
      end
    end
  end

  task automatic model_cmd(input logic [2:0] c, input logic [27:0] a);
    int idx;
    logic [127:0] d, cur;
    logic [15:0]  m;
    rexp_t e;
    idx = int'(a[14:3]);
    if (a[2:0] != 3'b000) err_m = 1'b1;
    cur = mem_m.exists(idx) ? mem_m[idx] : '0;
    if (c == 3'd0) begin
      if (wq_dat.size() == 0) err_m = 1'b1;
      else begin
        d = wq_dat.pop_front();
        m = wq_msk.pop_front();
        for (int b = 0; b < 16; b++) if (!m[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        mem_m[idx] = cur;
      end
    end else if (c == 3'd1) begin
      e.due = cyc + LAT;
      e.dat = cur;
      rq.push_back(e);
    end else begin
      err_m = 1'b1;
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [27:0] a, input logic with_cmd,
                       input logic with_dat, input logic [127:0] d, input logic [15:0] m,
                       input logic e);
    logic cdone, ddone;
    int   t;
    cdone = !with_cmd; ddone = !with_dat;
    en = with_cmd; cmd = c; addr = a; wren = with_dat; wdat = d; wmask = m; wend = e;
    t = 0;
    while (!(cdone && ddone)) begin
      if (wren && wrdy) begin
        wq_dat.push_back(d); wq_msk.push_back(m);
        if (!e) err_m = 1'b1;
        ddone = 1'b1;
      end
      if (en && rdy) begin
        acc_cyc = cyc;
        model_cmd(c, a);
        cdone = 1'b1;
      end
      @(negedge clk);
      if (cdone) en = 1'b0;
      if (ddone) wren = 1'b0;
      t++;
      if (t > 100) begin
        chk("handshake_timeout", {cdone, ddone}, 2'b11);
        en = 1'b0; wren = 1'b0;
        break;
      end
    end
  endtask

  task automatic wr(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    issue(3'd0, a, 1'b1, 1'b1, d, m, 1'b1);
  endtask

  task automatic rd_check(input logic [27:0] a, input logic [127:0] exp, input string tag);
    issue(3'd1, a, 1'b1, 1'b0, '0, '0, 1'b1);
    while (cyc < acc_cyc + LAT) begin
      if (cyc == acc_cyc + LAT - 1) chk({tag, "_early"}, rvld, 1'b0);
      @(negedge clk);
    end
    chk({tag, "_vld"}, rvld, 1'b1);
    chk({tag, "_dat"}, rdat, exp);
  endtask

  task automatic drain();
    int t = 0;
    while (rq.size() != 0 && t < 50) begin @(negedge clk); t++; end
    chk("drain", rq.size(), 0);
  endtask

  task automatic wait_calib(output int n);
    n = 0;
    while (!calib && n < 400) begin @(negedge clk); n++; end
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b1; en = 1'b0; wren = 1'b0;
    rq.delete(); wq_dat.delete(); wq_msk.delete(); err_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_calib(n);
    chk("recalib_cycles", n, CALIB);
  endtask

  initial begin
    int n, snap, i, t, op;
    logic [27:0]  alist [6];
    logic [27:0]  ra;
    logic [127:0] rd_v;
    rst = 1'b1; en = 1'b0; cmd = '0; addr = '0; wren = 1'b0; wdat = '0; wmask = '0; wend = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_calib", calib, 1'b0);
    chk("rst_app_rdy", rdy, 1'b0);
    chk("rst_wdf_rdy", wrdy, 1'b0);
    chk("rst_rd_valid", rvld, 1'b0);
    chk("rst_rd_data", rdat, 128'h0);
    chk("rst_proto_err", perr, 1'b0);

    rst = 1'b0;
    wait_calib(n);
    chk("calib_cycles", n, CALIB);
    chk("wdf_rdy_after_calib", wrdy, 1'b1);

    wr(28'h40, PAT, 16'h0000);
    rd_check(28'h40, PAT, "wr_rd_0x40");
    chk("perr_clean", perr, 1'b0);

    wr(28'h80, 128'h0, 16'h0000);
    wr(28'h80, '1, 16'h00FF);
    rd_check(28'h80, MPAT, "mask_0x80");

    for (int k = 0; k < 3; k++) begin
      issue(3'd0, 28'h0, 1'b0, 1'b1, {4{32'hC0DE0000 + 32'(k)}}, 16'h0, 1'b1);
      chk("wdf_rdy_level", wrdy, 1'(wq_dat.size() <= 2));
    end
    for (int k = 0; k < 3; k++) issue(3'd0, 28'h100 + 28'(k * 8), 1'b1, 1'b0, '0, '0, 1'b1);
    chk("wdf_rdy_drained", wrdy, 1'b1);
    rd_check(28'h108, {4{32'hC0DE0001}}, "fifo_order");

    drain();
    issue(3'd0, 28'h40, 1'b1, 1'b0, '0, '0, 1'b1);
    chk("perr_drop", perr, 1'b1);
    rd_check(28'h40, PAT, "drop_unchanged");

    issue(3'd1, 28'h80, 1'b1, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    snap = nvld;
    do_reset();
    chk("no_valid_after_rst", nvld, snap);
    chk("perr_after_rst", perr, 1'b0);
    rd_check(28'h80, MPAT, "mem_retained");

    issue(3'd3, 28'h80, 1'b1, 1'b0, '0, '0, 1'b1);
    chk("perr_bad_cmd", perr, 1'b1);
    rd_check(28'h80, MPAT, "bad_cmd_no_effect");

    drain(); do_reset();
    rd_check(28'h43, PAT, "misaligned_rd");
    chk("perr_misaligned", perr, 1'b1);
    rd_check(28'h8040, PAT, "alias_rd");

    drain(); do_reset();
    issue(3'd0, 28'h48, 1'b1, 1'b1, 128'hDEADBEEF_00000000_CAFEF00D_12345678, 16'h0, 1'b0);
    chk("perr_no_end", perr, 1'b1);
    rd_check(28'h48, 128'hDEADBEEF_00000000_CAFEF00D_12345678, "no_end_data");

    alist = '{28'h40, 28'h80, 28'h100, 28'h108, 28'h110, 28'h48};
    drain();
    snap = nvld;
    en = 1'b1; cmd = 3'd1; addr = alist[0]; i = 0; t = 0;
    while (i < 16 && t < 200) begin
      if (rdy) begin acc_cyc = cyc; model_cmd(3'd1, addr); i++; end
      @(negedge clk);
      if (i >= 16) en = 1'b0; else addr = alist[i % 6];
      t++;
    end
    en = 1'b0;
    drain();
    chk("b2b_count", nvld - snap, 16);

    for (int k = 0; k < 8; k++) wr(28'h200 + 28'(k * 8), {$urandom, $urandom, $urandom, $urandom}, 16'h0);
    for (int s = 0; s < 150; s++) begin
      op = $urandom_range(0, 2);
      ra = {13'($urandom), 12'(12'h040 + 12'($urandom_range(0, 7))), 3'b000};
      rd_v = {$urandom, $urandom, $urandom, $urandom};
      if (op == 0) wr(ra, rd_v, 16'($urandom));
      else if (op == 1) issue(3'd1, ra, 1'b1, 1'b0, '0, '0, 1'b1);
      else begin
        issue(3'd0, ra, 1'b0, 1'b1, rd_v, 16'($urandom), 1'b1);
        issue(3'd0, ra, 1'b1, 1'b0, '0, '0, 1'b1);
      end
    end
    drain();
    chk("perr_final", perr, err_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
